// File: rtl/lr3_input_cond.sv
// LR3 front-end conditioner: synchronizes the button and switch bank, debounces
// the button into a one-clock press strobe, and paces the display scan.
module lr3_input_cond #(
    parameter int DEB_LEN  = 50000,
    parameter int DISP_DIV = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    input  logic [3:0] SW,
    output logic       BTN_CE,
    output logic [3:0] DAT_O,
    output logic       DISP_CE
);

    localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam int DW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEB_LEN - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DISP_DIV - 1);

    logic          r_btn_m;
    logic          r_btn_s;
    logic [3:0]    r_sw_m;
    logic [3:0]    r_sw_s;
    logic [3:0]    r_dat;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;
    logic          r_btn_ce;
    logic [DW-1:0] r_dcnt;
    logic          r_disp_ce;
    logic          w_mismatch;
    logic          w_cnt_last;
    logic          w_dcnt_last;

    assign w_mismatch  = r_btn_s ^ r_deb;
    assign w_cnt_last  = (r_cnt == C_LAST);
    assign w_dcnt_last = (r_dcnt == D_LAST);

    // Two-flop synchronizers plus the output copy of the switch nibble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_btn_m <= 1'b0;
            r_btn_s <= 1'b0;
            r_sw_m  <= 4'h0;
            r_sw_s  <= 4'h0;
            r_dat   <= 4'h0;
        end else begin
            r_btn_m <= BTN;
            r_btn_s <= r_btn_m;
            r_sw_m  <= SW;
            r_sw_s  <= r_sw_m;
            r_dat   <= r_sw_s;
        end
    end

    // Any clock of agreement restarts the qualification window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (!w_mismatch) begin
            r_cnt <= '0;
        end else if (w_cnt_last) begin
            r_deb <= r_btn_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_deb_d  <= 1'b0;
            r_btn_ce <= 1'b0;
        end else begin
            r_deb_d  <= r_deb;
            r_btn_ce <= r_deb & ~r_deb_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dcnt    <= '0;
            r_disp_ce <= 1'b0;
        end else begin
            r_dcnt    <= w_dcnt_last ? '0 : r_dcnt + 1'b1;
            r_disp_ce <= w_dcnt_last;
        end
    end

    assign BTN_CE  = r_btn_ce;
    assign DAT_O   = r_dat;
    assign DISP_CE = r_disp_ce;

endmodule

// File: tb/tb_lr3_input_cond.sv
// Bench for lr3_input_cond: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the conditioner.
module tb_lr3_input_cond;

    localparam int DEB_LEN  = 4;
    localparam int DISP_DIV = 9;

    logic       CLK;
    logic       RST;
    logic       BTN;
    logic [3:0] SW;
    logic       BTN_CE;
    logic [3:0] DAT_O;
    logic       DISP_CE;

    int n_tests;
    int n_fail;

    lr3_input_cond #(
        .DEB_LEN (DEB_LEN),
        .DISP_DIV(DISP_DIV)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN    (BTN),
        .SW     (SW),
        .BTN_CE (BTN_CE),
        .DAT_O  (DAT_O),
        .DISP_CE(DISP_CE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: sync delay as queues, debounce as a run length of disagreeing
    // samples, display strobe as edges-since-reset modulo the period.
    logic       m_ce;
    logic       m_disp;
    logic [3:0] m_dat;
    logic       m_deb;
    logic       m_rose;
    int         m_run;
    int         m_since;
    logic       bq[$];
    logic [3:0] sq[$];

    always @(posedge CLK) begin : model_blk
        logic s;
        if (RST) begin
            bq = '{1'b0, 1'b0};
            sq = '{4'h0, 4'h0};
            m_deb = 1'b0;
            m_rose = 1'b0;
            m_run = 0;
            m_since = 0;
            m_ce = 1'b0;
            m_dat = 4'h0;
            m_disp = 1'b0;
        end else begin
            s = bq.pop_front();
            bq.push_back(BTN);
            sq.push_back(SW);
            m_dat = sq.pop_front();
            m_ce = m_rose;
            m_rose = 1'b0;
            if (s == m_deb) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DEB_LEN) begin
                    m_deb = s;
                    m_run = 0;
                    m_rose = s;
                end
            end
            m_since++;
            m_disp = (m_since % DISP_DIV) == 0;
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        BTN = 1'b0;
        SW  = 4'h0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if (BTN_CE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_btn_ce got %b want 0", BTN_CE);
        end
        n_tests++;
        if (DAT_O !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_dat got %h want 0", DAT_O);
        end
        n_tests++;
        if (DISP_CE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_disp_ce got %b want 0", DISP_CE);
        end
    endtask

    task automatic test_disp();
        logic want;
        RST = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            want = (i % DISP_DIV) == 0;
            n_tests++;
            if (DISP_CE !== want) begin
                n_fail++;
                $display("FAIL disp_period edge %0d got %b want %b",
                         i, DISP_CE, want);
            end
            n_tests++;
            if ({BTN_CE, DAT_O, DISP_CE} !== {m_ce, m_dat, m_disp}) begin
                n_fail++;
                $display("FAIL disp_model edge %0d got %b want %b", i,
                         {BTN_CE, DAT_O, DISP_CE}, {m_ce, m_dat, m_disp});
            end
        end
    endtask

    task automatic test_press();
        int cnt;
        int idx;
        cnt = 0;
        idx = -1;
        SW  = 4'h2;
        BTN = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge CLK);
            if (BTN_CE === 1'b1) begin
                cnt++;
                idx = i;
            end
            if (i == 2 || i == 3) begin
                n_tests++;
                if (DAT_O !== ((i == 3) ? 4'h2 : 4'h0)) begin
                    n_fail++;
                    $display("FAIL press_dat step %0d got %h", i, DAT_O);
                end
            end
            n_tests++;
            if ({BTN_CE, DAT_O, DISP_CE} !== {m_ce, m_dat, m_disp}) begin
                n_fail++;
                $display("FAIL press_model step %0d got %b want %b", i,
                         {BTN_CE, DAT_O, DISP_CE}, {m_ce, m_dat, m_disp});
            end
            if (i == 20) BTN = 1'b0;
        end
        n_tests++;
        if (cnt != 1 || idx != DEB_LEN + 3) begin
            n_fail++;
            $display("FAIL press_pulse got %0d pulses at %0d want 1 at %0d",
                     cnt, idx, DEB_LEN + 3);
        end
    endtask

    task automatic test_glitch(input int len, input int want);
        int cnt;
        cnt = 0;
        BTN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (BTN_CE === 1'b1) cnt++;
            n_tests++;
            if ({BTN_CE, DAT_O, DISP_CE} !== {m_ce, m_dat, m_disp}) begin
                n_fail++;
                $display("FAIL glitch%0d_model step %0d got %b want %b",
                         len, i, {BTN_CE, DAT_O, DISP_CE},
                         {m_ce, m_dat, m_disp});
            end
            if (i == len) BTN = 1'b0;
        end
        n_tests++;
        if (cnt != want) begin
            n_fail++;
            $display("FAIL glitch%0d_count got %0d want %0d", len, cnt, want);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int cnt;
        int idx;
        pat = 5'b01101;
        cnt = 0;
        idx = -1;
        BTN = pat[0];
        for (int i = 1; i <= 32; i++) begin
            @(negedge CLK);
            if (BTN_CE === 1'b1) begin
                cnt++;
                idx = i;
            end
            n_tests++;
            if ({BTN_CE, DAT_O, DISP_CE} !== {m_ce, m_dat, m_disp}) begin
                n_fail++;
                $display("FAIL bounce_model step %0d got %b want %b", i,
                         {BTN_CE, DAT_O, DISP_CE}, {m_ce, m_dat, m_disp});
            end
            BTN = (i < 5) ? pat[i] : (i < 20);
        end
        n_tests++;
        if (cnt != 1 || idx != 5 + DEB_LEN + 3) begin
            n_fail++;
            $display("FAIL bounce_pulse got %0d pulses at %0d want 1 at %0d",
                     cnt, idx, 5 + DEB_LEN + 3);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int idx;
        cnt = 0;
        idx = -1;
        BTN = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge CLK);
            if (BTN_CE === 1'b1) begin
                cnt++;
                idx = i;
            end
            if (i == 5) begin
                n_tests++;
                if ({BTN_CE, DAT_O, DISP_CE} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_clear got %b want 0",
                             {BTN_CE, DAT_O, DISP_CE});
                end
            end
            n_tests++;
            if ({BTN_CE, DAT_O, DISP_CE} !== {m_ce, m_dat, m_disp}) begin
                n_fail++;
                $display("FAIL rstmid_model step %0d got %b want %b", i,
                         {BTN_CE, DAT_O, DISP_CE}, {m_ce, m_dat, m_disp});
            end
            RST = (i == 4);
            if (i == 20) BTN = 1'b0;
        end
        n_tests++;
        if (cnt != 1 || idx != 5 + DEB_LEN + 3) begin
            n_fail++;
            $display("FAIL rstmid_pulse got %0d pulses at %0d want 1 at %0d",
                     cnt, idx, 5 + DEB_LEN + 3);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] nib[20];
        int cnt;
        int len;
        nib = '{4'h2, 4'h3, 4'h0, 4'hB, 4'h2, 4'h3, 4'h8, 4'h0, 4'h3, 4'hB,
                4'hA, 4'hD, 4'h9, 4'hF, 4'hC, 4'h7, 4'h1, 4'h2, 4'h1, 4'h9};
        cnt = 0;
        for (int p = 0; p < 20; p++) begin
            SW  = nib[p];
            len = 21 + int'($urandom_range(0, 3));
            for (int c = 0; c < len; c++) begin
                @(negedge CLK);
                if (BTN_CE === 1'b1) begin
                    cnt++;
                    n_tests++;
                    if (DAT_O !== nib[p]) begin
                        n_fail++;
                        $display("FAIL seq_dat press %0d got %h want %h",
                                 p, DAT_O, nib[p]);
                    end
                end
                n_tests++;
                if ({BTN_CE, DAT_O, DISP_CE} !== {m_ce, m_dat, m_disp}) begin
                    n_fail++;
                    $display("FAIL seq_model press %0d got %b want %b", p,
                             {BTN_CE, DAT_O, DISP_CE}, {m_ce, m_dat, m_disp});
                end
                BTN = (c >= 4 && c < 12);
            end
        end
        n_tests++;
        if (cnt != 20) begin
            n_fail++;
            $display("FAIL seq_count got %0d want 20", cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({BTN_CE, DAT_O, DISP_CE} !== {m_ce, m_dat, m_disp}) begin
                n_fail++;
                $display("FAIL rand_model cyc %0d got %b want %b", i,
                         {BTN_CE, DAT_O, DISP_CE}, {m_ce, m_dat, m_disp});
            end
            if ($urandom_range(0, 4) == 0) BTN = ~BTN;
            if ($urandom_range(0, 7) == 0) SW = 4'($urandom);
            RST = ($urandom_range(0, 149) == 0);
        end
        RST = 1'b0;
        BTN = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_disp();
        test_press();
        test_glitch(3, 0);
        test_glitch(4, 1);
        test_bounce();
        test_reset_mid();
        test_sequence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lr3_input_cond.md
Name: lr3_input_cond

Overview:
Front-end conditioner feeding the LR3 digit-entry/display core. Synchronizes the raw push-button and 4-bit switch bank, debounces the button, and emits a single-cycle BTN_CE per debounced press together with the synchronized DAT_O nibble. Also generates the periodic DISP_CE strobe that paces the 8-digit display scan. Outputs connect directly to LR3 BTN_CE / DAT_I / DISP_CE.

Parameters:
DEB_LEN, 50000, consecutive mismatching clocks required to accept a new button level; legal range >= 2; bench uses 4.
DISP_DIV, 1000, DISP_CE period in clocks; legal range >= 2; bench uses 9.

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
BTN  in  1  raw asynchronous push-button, active-high
SW   in  4  raw asynchronous switch nibble
BTN_CE  out  1  one-clock pulse per debounced press
DAT_O  out  4  synchronized switch value, to LR3 DAT_I
DISP_CE  out  1  one-clock display-scan strobe every DISP_DIV clocks

Behaviour:
- Reset is synchronous and active-high; one clock, CLK. While RST=1 at an edge, all registers clear: sync flops, debounced state, state delay, debounce counter, divider counter. BTN_CE=0, DAT_O=0, DISP_CE=0.
- Sync: two-flop synchronizer on BTN and each SW bit; btn_s and sw_s are second-stage outputs.
- DAT_O: registered copy of sw_s; raw SW change appears on DAT_O 3 edges later. No freeze on BTN_CE; LR3 samples DAT_I on BTN_CE. Switches are stable for >> 3 clocks around a press.
- Debounce: state register deb (reset 0) and counter cnt, width clog2(DEB_LEN).
  - btn_s == deb: cnt <= 0.
  - btn_s != deb and cnt < DEB_LEN-1: cnt <= cnt+1.
  - btn_s != deb and cnt == DEB_LEN-1: deb <= btn_s, cnt <= 0.
  - Any return to agreement restarts the count; a glitch shorter than DEB_LEN clocks is fully rejected.
- BTN_CE: registered; deb_d <= deb; BTN_CE <= deb & ~deb_d. Exactly one pulse per 0->1 transition of deb. None on release. None while held.
- Latency: if BTN=1 is first sampled at edge E0 and held, deb=1 after E0+DEB_LEN+1. BTN_CE is high for exactly the clock between E0+DEB_LEN+2 and E0+DEB_LEN+3.
- Release uses the same DEB_LEN qualification. A new press is accepted only after deb has returned to 0.
- Button held across reset release: deb restarts at 0, so one BTN_CE is produced DEB_LEN+2 edges after the first post-reset sample. RST during counting aborts it with no pulse.
- Divider: dcnt counts 0..DISP_DIV-1 and wraps to 0. DISP_CE <= (dcnt == DISP_DIV-1) is registered.
  - First DISP_CE is high after the DISP_DIV-th edge following reset release, then every DISP_DIV clocks.
  - It runs independently of BTN; simultaneous BTN_CE and DISP_CE are both asserted, with no priority.

Test Plan:
1. DEB_LEN=4, DISP_DIV=9, RST high 2 clocks -> all outputs 0. First DISP_CE after the 9th post-reset edge; then every 90 ns at 10 ns clock, exactly 1 clock wide.
2. SW=4'h2, BTN high 20 clocks -> DAT_O=2 after 3 edges. Exactly one BTN_CE, high between edges E0+6 and E0+7. No further pulse while held or on release.
3. BTN glitch high for 3 clocks, then low -> no BTN_CE, deb stays 0. Repeat with 4-clock high -> exactly one BTN_CE.
4. Bouncy press: 1,0,1,1,0 pattern over 5 clocks, then solid 1 -> single BTN_CE, timed from the last restart of the stable level.
5. BTN held, RST pulsed mid-debounce (cnt=2) -> no pulse during reset. After release, one BTN_CE 6 edges after the first post-reset sample of BTN.
6. Sequence of 20 presses with SW = 2,3,0,B,2,3,8,0,3,B,A,D,9,F,C,7,1,2,1,9 -> 20 BTN_CE pulses; DAT_O equals the listed nibble at each pulse.
